bus_xcvr_seq: RTL

//  Clocked, parametrised successor to the '245-style bidirectional bus transceiver.
//  - Drives W-bit buses A<->B under dir/oe_n control.
//  - Enforces a programmable enable delay and a contention-free direction turnaround
//    (dead time): the old side is released before the new side drives.
//  - Provides a delayed monitor copy of A on C and a sticky bus-contention detector.
//  - Sits between a CPU-side bus (A) and a peripheral bus (B).

---
 rtl/bus_xcvr_if.sv | 24 ++
 rtl/bus_xcvr_seq.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/bus_xcvr_if.sv
// Control and status bundle for bus_xcvr_seq; the A/B bus pins stay plain
// inout ports on the transceiver so tristate resolution stays on real nets.
interface bus_xcvr_if #(
  parameter int W = 8
);
  logic         oe_n;
  logic         dir;
  logic         clr_contention;
  logic [W-1:0] C;
  logic         busy;
  logic         drv_ab;
  logic         drv_ba;
  logic         contention;

  modport master (
    output oe_n, dir, clr_contention,
    input  C, busy, drv_ab, drv_ba, contention
  );

  modport slave (
    input  oe_n, dir, clr_contention,
    output C, busy, drv_ab, drv_ba, contention
  );
endinterface

// File: rtl/bus_xcvr_seq.sv
// Clocked '245-style bidirectional transceiver: enable delay, contention-free
// direction turnaround, delayed monitor copy of A and sticky contention flag.
module bus_xcvr_seq #(
  parameter int W        = 8,
  parameter int EN_CYC   = 4,
  parameter int TURN_CYC = 2,
  parameter int MON_LAT  = 10
) (
  input  logic        clk,
  input  logic        rst,
  bus_xcvr_if.slave   bif,
  inout  wire [W-1:0] A,
  inout  wire [W-1:0] B
);
  // state    | meaning
  // ST_OFF   | both sides released, waiting for oe_n low
  // ST_WAIT  | enable delay running, nothing driven yet
  // ST_DRIVE | side selected by r_dir_q is driven
  // ST_TURN  | dead time after a direction change, nothing driven

  localparam int CNT_MAX = (EN_CYC > TURN_CYC) ? EN_CYC : TURN_CYC;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] EN_LD   = CW'(EN_CYC - 1);
  localparam logic [CW-1:0] TURN_LD = CW'(TURN_CYC - 1);

  localparam logic [1:0] ST_OFF   = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_DRIVE = 2'd2;
  localparam logic [1:0] ST_TURN  = 2'd3;

  logic [1:0]    r_state;
  logic          r_dir_q;
  logic [CW-1:0] r_cnt;
  logic          r_drv_ab;
  logic          r_drv_ba;
  logic [W-1:0]  r_b_out;
  logic [W-1:0]  r_a_out;
  logic          r_contention;

  logic [1:0]    w_state_nx;
  logic          w_dir_nx;
  logic [CW-1:0] w_cnt_nx;
  logic          w_mismatch;

  always_comb begin
    w_state_nx = r_state;
    w_dir_nx   = r_dir_q;
    w_cnt_nx   = r_cnt;
    case (r_state)
      ST_OFF: begin
        if (!bif.oe_n) begin
          w_state_nx = ST_WAIT;
          w_dir_nx   = bif.dir;
          w_cnt_nx   = EN_LD;
        end
      end
      ST_WAIT: begin
        if (bif.oe_n) begin
          w_state_nx = ST_OFF;
        end else if (bif.dir != r_dir_q) begin
          w_dir_nx = bif.dir;
          w_cnt_nx = EN_LD;
        end else if (r_cnt == '0) begin
          w_state_nx = ST_DRIVE;
        end else begin
          w_cnt_nx = r_cnt - 1'b1;
        end
      end
      ST_DRIVE: begin
        if (bif.oe_n) begin
          w_state_nx = ST_OFF;
        end else if (bif.dir != r_dir_q) begin
          w_state_nx = ST_TURN;
          w_dir_nx   = bif.dir;
          w_cnt_nx   = TURN_LD;
        end
      end
      ST_TURN: begin
        if (bif.oe_n) begin
          w_state_nx = ST_OFF;
        end else begin
          // late toggles retarget the drive without extending the dead time
          w_dir_nx = bif.dir;
          if (r_cnt == '0) begin
            w_state_nx = ST_DRIVE;
          end else begin
            w_cnt_nx = r_cnt - 1'b1;
          end
        end
      end
      default: begin
        w_state_nx = ST_OFF;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_OFF;
      r_dir_q  <= 1'b1;
      r_cnt    <= '0;
      r_drv_ab <= 1'b0;
      r_drv_ba <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_dir_q  <= w_dir_nx;
      r_cnt    <= w_cnt_nx;
      // enables come straight from flops so the pad drivers never glitch
      r_drv_ab <= (w_state_nx == ST_DRIVE) &&  w_dir_nx;
      r_drv_ba <= (w_state_nx == ST_DRIVE) && !w_dir_nx;
    end
  end

  assign w_mismatch = (r_drv_ab && (B !== r_b_out)) ||
                      (r_drv_ba && (A !== r_a_out));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_b_out      <= '0;
      r_a_out      <= '0;
      r_contention <= 1'b0;
    end else begin
      r_b_out <= A;
      r_a_out <= B;
      if (bif.clr_contention) begin
        r_contention <= 1'b0;
      end else if (w_mismatch) begin
        r_contention <= 1'b1;
      end
    end
  end

  assign B = r_drv_ab ? r_b_out : {W{1'bz}};
  assign A = r_drv_ba ? r_a_out : {W{1'bz}};

  generate
    if (MON_LAT == 0) begin : g_mon_comb
      assign bif.C = A;
    end else begin : g_mon_pipe
      logic [W-1:0] r_mon [MON_LAT];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < MON_LAT; i++) begin
            r_mon[i] <= '0;
          end
        end else begin
          r_mon[0] <= A;
          for (int i = 1; i < MON_LAT; i++) begin
            r_mon[i] <= r_mon[i-1];
          end
        end
      end

      assign bif.C = r_mon[MON_LAT-1];
    end
  endgenerate

  assign bif.busy       = (r_state == ST_WAIT) || (r_state == ST_TURN);
  assign bif.drv_ab     = r_drv_ab;
  assign bif.drv_ba     = r_drv_ba;
  assign bif.contention = r_contention;
endmodule
